// File: rtl/spdif_pkg.sv
// Shared constants and types for the S/PDIF subframe assembler.
package spdif_pkg;

    // Decoded bits per subframe (slots 4..31, preamble excluded)
    localparam int SUBFRAME_DATA_BITS = 28;

    // Slot positions, counted from the first decoded bit of a subframe
    localparam int AUX_LSB   = 0;
    localparam int AUDIO_LSB = 4;
    localparam int V_IDX     = 24;
    localparam int U_IDX     = 25;
    localparam int C_IDX     = 26;
    localparam int P_IDX     = 27;

    localparam int AUDIO_BITS  = 20;
    localparam int SAMPLE_BITS = 24;

    // Channel-status block geometry
    localparam int CS_BITS          = 32;
    localparam int FRAMES_PER_BLOCK = 192;

    typedef logic [4:0] bit_idx_t;

    typedef struct packed {
        logic [SAMPLE_BITS-1:0] sample;
        logic                   v;
        logic                   u;
        logic                   c;
        logic                   parity_err;
        logic                   channel;
        logic [7:0]             frame;
    } subframe_t;

endpackage

// File: rtl/spdif_cs_collector.sv
// Gathers the C bit of frames 0..31 of one channel into a 32-bit
// channel-status word, publishing it when frame 31 completes.
module spdif_cs_collector
    import spdif_pkg::*;
#(
    parameter bit CS_CHANNEL = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               done_i,
    input  logic               c_i,
    input  logic               ch_i,
    input  logic [7:0]         fr_i,
    output logic [CS_BITS-1:0] cs_word_o,
    output logic               cs_valid_o
);

    logic [CS_BITS-1:0] cs_acc_q, cs_acc_d;
    logic [CS_BITS-1:0] cs_word_q;
    logic               cs_valid_q;
    logic               hit;
    logic               last;

    // Next accumulator value; frame 0 opens a fresh block.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hit      = done_i && (ch_i == CS_CHANNEL) && (fr_i < 8'(CS_BITS));
        last     = hit && (fr_i == 8'(CS_BITS - 1));
        cs_acc_d = cs_acc_q;
        if (hit) begin
            if (fr_i == 8'd0) begin
                cs_acc_d = '0;
            end
            cs_acc_d[fr_i[4:0]] = c_i;
        end
    end

    // Accumulator, published word and its one-cycle strobe.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_acc_q   <= '0;
            cs_word_q  <= '0;
            cs_valid_q <= 1'b0;
        end else begin
            cs_acc_q   <= cs_acc_d;
            cs_valid_q <= last;
            if (last) begin
                cs_word_q <= cs_acc_d;
            end
        end
    end

    assign cs_word_o  = cs_word_q;
    assign cs_valid_o = cs_valid_q;

endmodule

// File: rtl/spdif_subframe_assembler.sv
// Rebuilds S/PDIF subframes from the decoded serial bit stream and emits
// one parallel sample with V/U/C flags, parity check and channel status.
module spdif_subframe_assembler
    import spdif_pkg::*;
#(
    parameter bit SAMPLE_24  = 1'b1,
    parameter bit CS_CHANNEL = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vin,
    input  logic                   din,
    input  logic [7:0]             frame_counter,
    input  logic                   channel,
    output logic [SAMPLE_BITS-1:0] sample,
    output logic                   sample_channel,
    output logic [7:0]             sample_frame,
    output logic                   v_bit,
    output logic                   u_bit,
    output logic                   c_bit,
    output logic                   parity_err,
    output logic                   sample_valid,
    output logic [CS_BITS-1:0]     cs_word,
    output logic                   cs_valid,
    output logic                   sync_err
);

    // Holds slots idx 0..26; idx 27 (P) only feeds the parity accumulator
    logic [SUBFRAME_DATA_BITS-2:0] shift_q, shift_d;
    bit_idx_t                      bit_cnt_q, bit_cnt_d;
    logic                          parity_q, parity_d;
    logic                          cap_ch_q, cap_ch_d;
    logic [7:0]                    cap_fr_q, cap_fr_d;
    subframe_t                     sf_q, sf_d;
    logic                          sample_valid_q;
    logic                          sync_err_q;
    logic                          mismatch;
    logic                          start;
    logic                          complete;

    // Bit consumption, resync on channel/frame change and subframe completion.
    always_comb begin
        mismatch  = vin && (bit_cnt_q != '0) &&
                    ((channel != cap_ch_q) || (frame_counter != cap_fr_q));
        start     = vin && ((bit_cnt_q == '0) || mismatch);
        complete  = vin && !mismatch && (bit_cnt_q == bit_idx_t'(P_IDX));
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        cap_ch_d  = cap_ch_q;
        cap_fr_d  = cap_fr_q;
        sf_d      = sf_q;
        if (vin) begin
            shift_d = {din, shift_q[SUBFRAME_DATA_BITS-2:1]};
            if (start) begin
                cap_ch_d  = channel;
                cap_fr_d  = frame_counter;
                parity_d  = din;
                bit_cnt_d = bit_idx_t'(1);
            end else begin
                parity_d  = parity_q ^ din;
                bit_cnt_d = complete ? '0 : bit_cnt_q + bit_idx_t'(1);
            end
        end
        if (complete) begin
            // shift_q already holds idx 0..26 with idx 0 at bit 0
            sf_d.sample     = SAMPLE_24 ? shift_q[AUX_LSB +: SAMPLE_BITS]
                                        : {shift_q[AUDIO_LSB +: AUDIO_BITS], 4'b0000};
            sf_d.v          = shift_q[V_IDX];
            sf_d.u          = shift_q[U_IDX];
            sf_d.c          = shift_q[C_IDX];
            sf_d.parity_err = parity_d;
            sf_d.channel    = cap_ch_q;
            sf_d.frame      = cap_fr_q;
        end
    end

    // Assembly state plus registered outputs and strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            parity_q       <= 1'b0;
            cap_ch_q       <= 1'b0;
            cap_fr_q       <= '0;
            sf_q           <= '0;
            sample_valid_q <= 1'b0;
            sync_err_q     <= 1'b0;
        end else begin
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            parity_q       <= parity_d;
            cap_ch_q       <= cap_ch_d;
            cap_fr_q       <= cap_fr_d;
            sf_q           <= sf_d;
            sample_valid_q <= complete;
            sync_err_q     <= mismatch;
        end
    end

    spdif_cs_collector #(
        .CS_CHANNEL (CS_CHANNEL)
    ) u_cs (
        .clk        (clk),
        .rst        (rst),
        .done_i     (complete),
        .c_i        (shift_q[C_IDX]),
        .ch_i       (cap_ch_q),
        .fr_i       (cap_fr_q),
        .cs_word_o  (cs_word),
        .cs_valid_o (cs_valid)
    );

    assign sample         = sf_q.sample;
    assign sample_channel = sf_q.channel;
    assign sample_frame   = sf_q.frame;
    assign v_bit          = sf_q.v;
    assign u_bit          = sf_q.u;
    assign c_bit          = sf_q.c;
    assign parity_err     = sf_q.parity_err;
    assign sample_valid   = sample_valid_q;
    assign sync_err       = sync_err_q;

endmodule

// File: tb/tb_spdif_subframe_assembler.sv
// Self-checking bench: two assembler instances (24-bit and 20-bit sample
// modes) share one stimulus stream; strobed outputs are logged on the
// falling edge and compared against a subframe-level reference model.
module tb_spdif_subframe_assembler;
    import spdif_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vin = 1'b0;
    logic        din = 1'b0;
    logic [7:0]  frame_counter = 8'd0;
    logic        channel = 1'b0;

    logic [23:0] s24, s20;
    logic        sch24, sch20, v24, v20, u24, u20, c24, c20, p24, p20;
    logic [7:0]  sfr24, sfr20;
    logic        sv24, sv20, csv24, csv20, se24, se20;
    logic [31:0] csw24, csw20;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_put = 0;

    typedef struct packed {
        logic [23:0] s24;
        logic [23:0] s20;
        logic        v;
        logic        u;
        logic        c;
        logic        p24;
        logic        p20;
        logic        ch;
        logic [7:0]  fr;
        logic [31:0] cyc;
    } obs_t;

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] cyc;
    } cs_ev_t;

    obs_t   obs_q[$];
    cs_ev_t cs_q[$];
    int     se_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spdif_subframe_assembler #(.SAMPLE_24(1'b1), .CS_CHANNEL(1'b0)) dut24 (
        .clk(clk), .rst(rst), .vin(vin), .din(din),
        .frame_counter(frame_counter), .channel(channel),
        .sample(s24), .sample_channel(sch24), .sample_frame(sfr24),
        .v_bit(v24), .u_bit(u24), .c_bit(c24), .parity_err(p24),
        .sample_valid(sv24), .cs_word(csw24), .cs_valid(csv24), .sync_err(se24)
    );

    spdif_subframe_assembler #(.SAMPLE_24(1'b0), .CS_CHANNEL(1'b0)) dut20 (
        .clk(clk), .rst(rst), .vin(vin), .din(din),
        .frame_counter(frame_counter), .channel(channel),
        .sample(s20), .sample_channel(sch20), .sample_frame(sfr20),
        .v_bit(v20), .u_bit(u20), .c_bit(c20), .parity_err(p20),
        .sample_valid(sv20), .cs_word(csw20), .cs_valid(csv20), .sync_err(se20)
    );

    // Strobe logger, sampled away from the active edge
    always @(negedge clk) begin
        if (sv24 || sv20)
            obs_q.push_back({s24, s20, v24, u24, c24, p24, p20, sch24, sfr24, 32'(cyc)});
        if (csv24)
            cs_q.push_back({csw24, 32'(cyc)});
        if (se24)
            se_q.push_back(cyc);
    end

    // Reference model: what a complete 28-bit subframe must produce
    function automatic obs_t model(input logic [27:0] w, input logic ch,
                                   input logic [7:0] fr, input int at);
        obs_t o;
        o.s24 = 24'(w % (1 << 24));
        o.s20 = 24'((w % (1 << 24)) / 16 * 16);
        o.v   = w[24];
        o.u   = w[25];
        o.c   = w[26];
        o.p24 = ($countones(w) % 2) != 0;
        o.p20 = o.p24;
        o.ch  = ch;
        o.fr  = fr;
        o.cyc = 32'(at);
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("s24=%h s20=%h v=%b u=%b c=%b perr=%b/%b ch=%b fr=%0d cyc=%0d",
                         o.s24, o.s20, o.v, o.u, o.c, o.p24, o.p20, o.ch, o.fr, o.cyc);
    endfunction

    task automatic put(input logic v, input logic d, input logic ch, input logic [7:0] fr);
        @(negedge clk);
        vin = v;
        din = d;
        channel = ch;
        frame_counter = fr;
        if (v) last_put = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(1'b0, 1'($urandom), channel, frame_counter);
    endtask

    task automatic send_bits(input logic [27:0] w, input int nbits, input logic ch,
                             input logic [7:0] fr, input int gap);
        for (int i = 0; i < nbits; i++) begin
            for (int g = 0; g < gap; g++) put(1'b0, 1'($urandom), ch, fr);
            put(1'b1, w[i], ch, fr);
        end
    endtask

    task automatic test_reset;
        logic [115:0] o24, o20;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        o24 = {s24, sch24, sfr24, v24, u24, c24, p24, sv24, csw24, csv24, se24};
        o20 = {s20, sch20, sfr20, v20, u20, c20, p20, sv20, csw20, csv20, se20};
        total++;
        if (o24 !== '0) begin
            bad++;
            $display("FAIL reset_24: outputs=%h want 0", o24);
        end
        total++;
        if (o20 !== '0) begin
            bad++;
            $display("FAIL reset_20: outputs=%h want 0", o20);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_reset_mid;
        logic [27:0] wa, wb;
        obs_t exp, got;
        obs_q.delete();
        se_q.delete();
        wa = 28'($urandom);
        wb = 28'($urandom);
        send_bits(wa, 10, 1'b0, 8'd3, 0);
        @(negedge clk);
        rst = 1'b1;
        vin = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send_bits(wb, 28, 1'b1, 8'd7, 0);
        exp = model(wb, 1'b1, 8'd7, last_put + 1);
        idle(3);
        total++;
        if (obs_q.size() != 1 || se_q.size() != 0) begin
            bad++;
            $display("FAIL reset_mid_count: samples=%0d syncerr=%0d want 1/0", obs_q.size(), se_q.size());
        end
        got = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL reset_mid_sample: got %s want %s", fmt(got), fmt(exp));
        end
    endtask

    task automatic test_basic(input logic [27:0] w, input int gap, input string name);
        obs_t exp, got;
        obs_q.delete();
        send_bits(w, 28, 1'b0, 8'd5, gap);
        exp = model(w, 1'b0, 8'd5, last_put + 1);
        idle(3);
        total++;
        if (obs_q.size() != 1) begin
            bad++;
            $display("FAIL %s_count: samples=%0d want 1", name, obs_q.size());
        end
        got = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %s want %s", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic test_sync;
        logic [27:0] wa, wb;
        int          se_at;
        obs_t        exp, got;
        obs_q.delete();
        se_q.delete();
        wa = 28'($urandom);
        wb = 28'($urandom);
        send_bits(wa, 12, 1'b0, 8'd9, 0);
        put(1'b1, wb[0], 1'b1, 8'd9);
        se_at = last_put + 1;
        for (int i = 1; i < 28; i++) put(1'b1, wb[i], 1'b1, 8'd9);
        exp = model(wb, 1'b1, 8'd9, last_put + 1);
        idle(3);
        total++;
        if (se_q.size() != 1 || (se_q.size() == 1 && se_q[0] != se_at)) begin
            bad++;
            $display("FAIL sync_err: count=%0d first_cyc=%0d want 1 at %0d",
                     se_q.size(), (se_q.size() != 0) ? se_q[0] : -1, se_at);
        end
        total++;
        if (obs_q.size() != 1) begin
            bad++;
            $display("FAIL sync_count: samples=%0d want 1", obs_q.size());
        end
        got = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL sync_sample: got %s want %s", fmt(got), fmt(exp));
        end
    endtask

    task automatic test_back_to_back;
        obs_t        exp[6];
        obs_t        got;
        logic [27:0] w;
        logic [7:0]  frs[6] = '{8'd191, 8'd191, 8'd0, 8'd0, 8'd1, 8'd1};
        obs_q.delete();
        se_q.delete();
        for (int k = 0; k < 6; k++) begin
            w = 28'($urandom);
            send_bits(w, 28, 1'(k % 2), frs[k], 0);
            exp[k] = model(w, 1'(k % 2), frs[k], last_put + 1);
        end
        idle(3);
        total++;
        if (obs_q.size() != 6 || se_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_count: samples=%0d syncerr=%0d want 6/0", obs_q.size(), se_q.size());
        end
        for (int k = 0; k < 6; k++) begin
            got = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
            total++;
            if (got !== exp[k]) begin
                bad++;
                $display("FAIL b2b_%0d: got %s want %s", k, fmt(got), fmt(exp[k]));
            end
        end
    endtask

    task automatic test_random;
        logic [27:0] w;
        logic        ch;
        logic [7:0]  fr;
        obs_t        exp, got;
        for (int k = 0; k < 8; k++) begin
            obs_q.delete();
            w  = 28'($urandom);
            ch = 1'($urandom_range(0, 1));
            fr = 8'($urandom_range(0, FRAMES_PER_BLOCK - 1));
            send_bits(w, 28, ch, fr, $urandom_range(0, 3));
            exp = model(w, ch, fr, last_put + 1);
            idle(2);
            got = (obs_q.size() == 1) ? obs_q.pop_front() : '0;
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL rand_%0d: got %s want %s", k, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_cs;
        logic [31:0] pat = 32'h8000_0005;
        logic [27:0] w;
        int          want_at = 0;
        cs_ev_t      ev;
        obs_q.delete();
        cs_q.delete();
        for (int f = 0; f < CS_BITS; f++) begin
            w = 28'($urandom);
            w[C_IDX] = pat[f];
            send_bits(w, 28, 1'b0, 8'(f), 0);
            if (f == CS_BITS - 1) want_at = last_put + 1;
            w = 28'($urandom);
            w[C_IDX] = ~pat[f];
            send_bits(w, 28, 1'b1, 8'(f), 0);
        end
        idle(3);
        total++;
        if (cs_q.size() != 1) begin
            bad++;
            $display("FAIL cs_count: strobes=%0d want 1", cs_q.size());
        end
        ev = (cs_q.size() != 0) ? cs_q.pop_front() : '0;
        total++;
        if (ev.w !== pat || ev.cyc != 32'(want_at)) begin
            bad++;
            $display("FAIL cs_word: got %h at %0d want %h at %0d", ev.w, ev.cyc, pat, want_at);
        end
        total++;
        if (obs_q.size() != 2 * CS_BITS) begin
            bad++;
            $display("FAIL cs_samples: samples=%0d want %0d", obs_q.size(), 2 * CS_BITS);
        end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_basic(28'hE123456, 0, "basic");
        test_basic(28'h6123456, 0, "parity_flip");
        test_basic(28'hE123456, 3, "gaps");
        test_sync();
        test_back_to_back();
        test_random();
        test_cs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
